// File: rtl/game_tick_scheduler_pkg.sv
// Shared types and helpers for the game tick scheduler.
package game_tick_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    // Shortened tick period after a level-up, floored at floor_v. Worked in int
    // so a small period minus the step can never underflow.
    function automatic int next_period(input int cur, input int step, input int floor_v);
        if (cur >= floor_v + step)
            return cur - step;
        else
            return floor_v;
    endfunction

endpackage

// File: rtl/game_tick_scheduler_tick_divider.sv
// Programmable period counter. Counts while en is high, wraps when it reaches
// period-1 and emits a registered one-cycle wrap pulse in the following cycle.
// fire is the same-cycle wrap decision, so the parent can update period state
// on the edge that raises wrap.
module game_tick_scheduler_tick_divider #(
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic             fire,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;

    // Wrap decision from the registered count and the current period.
    always_comb begin
        fire = en && (cnt == period - CNT_W'(1));
    end

    // Count register and registered wrap pulse; clr takes precedence over counting.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= fire && !clr;
            if (clr || fire)
                cnt <= '0;
            else if (en)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_tick_scheduler.sv
// Game timebase: IDLE/RUN/PAUSE sequencer around a programmable divider. The
// tick period shrinks by STEP every TICKS_PER_LEVEL ticks until MAX_LEVEL.
module game_tick_scheduler
    import game_tick_scheduler_pkg::*;
#(
    parameter int BASE_DIV        = 8,
    parameter int STEP            = 2,
    parameter int MIN_DIV         = 4,
    parameter int TICKS_PER_LEVEL = 3,
    parameter int MAX_LEVEL       = 3,
    parameter int LEVEL_W         = 3,
    parameter int CNT_W           = $clog2(BASE_DIV + 1)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Pause,
    input  logic               Stop,
    input  logic               Level_clear,
    output logic               Tick,
    output logic [LEVEL_W-1:0] Level,
    output logic [CNT_W-1:0]   Div_value,
    output logic               Max_level,
    output logic               Running,
    output logic               Paused
);

    localparam int TC_W = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;

    state_t            state, state_nxt;
    logic              cnt_en;
    logic              cnt_clr;
    logic              stop_clr;
    logic              level_clr;
    logic              fire;
    logic [TC_W-1:0]   tick_cnt;
    logic [CNT_W-1:0]  div_dec;

    // State register.
    always_ff @(posedge Clock) begin
        if (!Reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and divider controls; Stop beats Pause beats Start.
    always_comb begin
        state_nxt = state;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        stop_clr  = 1'b0;
        level_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clr   = 1'b1;
                level_clr = Level_clear;
                if (Start)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (Stop) begin
                    state_nxt = ST_IDLE;
                    cnt_clr   = 1'b1;
                    stop_clr  = 1'b1;
                end else if (Pause) begin
                    state_nxt = ST_PAUSE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (Stop) begin
                    state_nxt = ST_IDLE;
                    cnt_clr   = 1'b1;
                    stop_clr  = 1'b1;
                end else if (!Pause) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    game_tick_scheduler_tick_divider #(
        .CNT_W (CNT_W)
    ) u_tick_divider (
        .Clock  (Clock),
        .Reset  (Reset),
        .en     (cnt_en),
        .clr    (cnt_clr),
        .period (Div_value),
        .fire   (fire),
        .wrap   (Tick)
    );

    // Period for the next level.
    always_comb begin
        div_dec = CNT_W'(next_period(int'(Div_value), STEP, MIN_DIV));
    end

    // Level and period bookkeeping; updates land on the edge that raises Tick.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Level     <= '0;
            Div_value <= CNT_W'(BASE_DIV);
            tick_cnt  <= '0;
        end else if (level_clr) begin
            Level     <= '0;
            Div_value <= CNT_W'(BASE_DIV);
            tick_cnt  <= '0;
        end else if (stop_clr) begin
            tick_cnt  <= '0;
        end else if (fire) begin
            if (tick_cnt == TC_W'(TICKS_PER_LEVEL - 1)) begin
                tick_cnt <= '0;
                if (Level < LEVEL_W'(MAX_LEVEL)) begin
                    Level     <= Level + LEVEL_W'(1);
                    Div_value <= div_dec;
                end
            end else begin
                tick_cnt <= tick_cnt + TC_W'(1);
            end
        end
    end

    // Status flags decoded from registered state.
    always_comb begin
        Max_level = (Level == LEVEL_W'(MAX_LEVEL));
        Running   = (state == ST_RUN);
        Paused    = (state == ST_PAUSE);
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench for game_tick_scheduler: a countdown-based reference model
// pushes expected outputs per cycle; a monitor pops and compares them.
module tb_game_tick_scheduler;

    localparam int BASE_DIV  = 8;
    localparam int STEP      = 2;
    localparam int MIN_DIV   = 4;
    localparam int TPL       = 3;
    localparam int MAX_LEVEL = 3;

    logic       Clock = 1'b0;
    logic       Reset, Start, Pause, Stop, Level_clear;
    logic       Tick;
    logic [2:0] Level;
    logic [3:0] Div_value;
    logic       Max_level, Running, Paused;

    game_tick_scheduler dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Pause       (Pause),
        .Stop        (Stop),
        .Level_clear (Level_clear),
        .Tick        (Tick),
        .Level       (Level),
        .Div_value   (Div_value),
        .Max_level   (Max_level),
        .Running     (Running),
        .Paused      (Paused)
    );

    always #10 Clock = ~Clock;

    typedef struct {
        logic tick;
        int   level;
        int   div;
        logic maxl;
        logic run;
        logic paused;
    } exp_t;

    typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_t;

    exp_t  sb_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    ticks_seen = 0;
    logic  done = 1'b0;

    mode_t m_mode      = M_IDLE;
    int    m_remaining = 0;
    int    m_tcount    = 0;
    int    m_level     = 0;

    function automatic int period_of(input int lvl);
        int p;
        p = BASE_DIV - STEP * lvl;
        return (p < MIN_DIV) ? MIN_DIV : p;
    endfunction

    // One clock: drive inputs away from the edge, then advance the model.
    task automatic cycle(input logic rst, input logic st, input logic pa,
                         input logic sp, input logic cl);
        exp_t e;
        @(negedge Clock);
        Reset = rst; Start = st; Pause = pa; Stop = sp; Level_clear = cl;
        @(posedge Clock);
        e.tick = 1'b0;
        if (!rst) begin
            m_mode = M_IDLE; m_remaining = 0; m_tcount = 0; m_level = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (cl) begin m_level = 0; m_tcount = 0; end
                    if (st) begin m_mode = M_RUN; m_remaining = period_of(m_level); end
                end
                M_RUN: begin
                    if (sp) begin
                        m_mode = M_IDLE; m_tcount = 0;
                    end else if (pa) begin
                        m_mode = M_PAUSE;
                    end else begin
                        m_remaining--;
                        if (m_remaining == 0) begin
                            e.tick = 1'b1;
                            m_tcount++;
                            if (m_tcount == TPL) begin
                                m_tcount = 0;
                                if (m_level < MAX_LEVEL) m_level++;
                            end
                            m_remaining = period_of(m_level);
                        end
                    end
                end
                M_PAUSE: begin
                    if (sp) begin
                        m_mode = M_IDLE; m_tcount = 0;
                    end else if (!pa) begin
                        m_mode = M_RUN;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        e.level  = m_level;
        e.div    = period_of(m_level);
        e.maxl   = (m_level == MAX_LEVEL);
        e.run    = (m_mode == M_RUN);
        e.paused = (m_mode == M_PAUSE);
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
    endtask

    // Monitor: compare the registered outputs just after each edge.
    always @(posedge Clock) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (Tick === 1'b1) ticks_seen++;
            if (Tick !== e.tick || int'(Level) != e.level || int'(Div_value) != e.div ||
                Max_level !== e.maxl || Running !== e.run || Paused !== e.paused) begin
                failures++;
                $display("FAIL outputs t=%0t got tick=%b lvl=%0d div=%0d max=%b run=%b pau=%b want tick=%b lvl=%0d div=%0d max=%b run=%b pau=%b",
                         $time, Tick, Level, Div_value, Max_level, Running, Paused,
                         e.tick, e.level, e.div, e.maxl, e.run, e.paused);
            end
        end
    end

    initial begin
        repeat (20000) @(posedge Clock);
        if (!done) begin
            failures++;
            $display("FAIL watchdog expired t=%0t", $time);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        int pause_left;
        logic pa;
        Reset = 1'b0; Start = 1'b0; Pause = 1'b0; Stop = 1'b0; Level_clear = 1'b0;

        // Reset, start, climb through all levels and beyond.
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 1);
        @(negedge Clock);
        checks++;
        if (Tick !== 1'b0 || Level !== 3'd0 || Div_value !== 4'(BASE_DIV) ||
            Max_level !== 1'b0 || Running !== 1'b0 || Paused !== 1'b0) begin
            failures++;
            $display("FAIL reset state t=%0t tick=%b lvl=%0d div=%0d max=%b run=%b pau=%b",
                     $time, Tick, Level, Div_value, Max_level, Running, Paused);
        end
        cycle(1, 1, 0, 0, 0);
        idle(110);
        @(negedge Clock);
        checks++;
        if (ticks_seen < 12) begin
            failures++;
            $display("FAIL expired wait for ticks t=%0t ticks_seen=%0d", $time, ticks_seen);
        end

        // Stop+Pause+Start together in RUN; Level_clear in RUN then IDLE.
        cycle(1, 1, 1, 1, 0);
        idle(2);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        idle(3);
        cycle(1, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1);
        idle(2);

        // Reset mid-count, then restart.
        cycle(1, 1, 0, 0, 0);
        idle(4);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        idle(10);
        cycle(1, 0, 0, 1, 0);

        // Pause at count 5 for 10 cycles, then resume.
        cycle(1, 1, 0, 0, 0);
        idle(5);
        for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0, 0);
        idle(10);
        cycle(1, 0, 0, 1, 0);

        // Stop exactly on the wrap cycle.
        cycle(1, 1, 0, 0, 0);
        idle(7);
        cycle(1, 0, 0, 1, 0);
        idle(3);
        cycle(1, 1, 0, 0, 0);
        idle(12);

        // Randomized traffic.
        pause_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (pause_left > 0) begin
                pa = 1'b1;
                pause_left--;
            end else if ($urandom_range(0, 39) == 0) begin
                pa = 1'b1;
                pause_left = $urandom_range(1, 12);
            end else begin
                pa = 1'b0;
            end
            cycle(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 7) == 0),
                  pa,
                  ($urandom_range(0, 89) == 0),
                  ($urandom_range(0, 29) == 0));
        end

        idle(2);
        @(negedge Clock);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
